// File: rtl/ucaspian_dendrite.sv
// Per-step dendrite accumulator: sums signed weights per neuron during a step,
// then drains touched entries in ascending address order to the neuron port.
//
// state | meaning
// ACCUM | accept weights into the read-modify-write pipeline
// SCAN  | walk ptr over the bitmap looking for touched entries
// LOAD  | RAM data for ptr is ready; register the output word
// SEND  | hold neuron_vld until neuron_rdy, then retire the entry
// CLEAR | zero RAM and bitmap one address per cycle
module ucaspian_dendrite #(
    parameter int ADDR_W   = 8,
    parameter int CHARGE_W = 16,
    parameter int WEIGHT_W = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                clear_act,
    output logic                clear_done,
    input  logic                next_step,
    output logic                step_done,
    input  logic [ADDR_W-1:0]   syn_addr,
    input  logic [WEIGHT_W-1:0] syn_weight,
    input  logic                syn_vld,
    output logic                syn_rdy,
    output logic [ADDR_W-1:0]   neuron_addr,
    output logic [CHARGE_W-1:0] neuron_charge,
    output logic                neuron_vld,
    input  logic                neuron_rdy
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {ST_ACCUM, ST_SCAN, ST_LOAD, ST_SEND, ST_CLEAR} state_t;
    state_t state, state_nxt;

    logic                run, step_pending, step_again;
    logic                p1_vld, p1_fwd;
    logic [ADDR_W-1:0]   p1_addr, ptr;
    logic [WEIGHT_W-1:0] p1_weight;
    logic [CHARGE_W-1:0] ram_q, wr_q, base, sat;
    logic [CHARGE_W:0]   sum;
    logic [DEPTH-1:0]    touched;
    logic [CHARGE_W-1:0] mem [DEPTH];

    logic                accept, ptr_last, acc_we, clr_we, ram_we, idle;
    logic [ADDR_W-1:0]   ram_waddr, rd_addr;
    logic [CHARGE_W-1:0] ram_wdata;

    assign accept   = syn_vld && syn_rdy;
    assign ptr_last = &ptr;

    // Untouched entries read as zero, so a drain never has to rewrite the RAM.
    always_comb begin
        base = p1_fwd ? wr_q : (touched[p1_addr] ? ram_q : '0);
        sum  = {base[CHARGE_W-1], base}
             + {{(CHARGE_W+1-WEIGHT_W){p1_weight[WEIGHT_W-1]}}, p1_weight};
        sat  = sum[CHARGE_W-1:0];
        if (sum[CHARGE_W] != sum[CHARGE_W-1])
            sat = sum[CHARGE_W] ? {1'b1, {(CHARGE_W-1){1'b0}}} : {1'b0, {(CHARGE_W-1){1'b1}}};
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= ST_ACCUM;
        else if (enable)
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clear_act && state != ST_CLEAR) begin
            state_nxt = ST_CLEAR;
        end else begin
            case (state)
                ST_ACCUM: if (step_pending && !p1_vld) state_nxt = ST_SCAN;
                ST_SCAN:  if (touched[ptr]) state_nxt = ST_LOAD;
                          else if (ptr_last) state_nxt = ST_ACCUM;
                ST_LOAD:  state_nxt = ST_SEND;
                ST_SEND:  if (neuron_rdy) state_nxt = ptr_last ? ST_ACCUM : ST_SCAN;
                ST_CLEAR: if (clear_done && !clear_act) state_nxt = ST_ACCUM;
                default:  state_nxt = ST_ACCUM;
            endcase
        end
    end

    always_comb begin
        syn_rdy   = run && enable && state == ST_ACCUM && !step_pending && !clear_act;
        acc_we    = p1_vld && !clear_act && state == ST_ACCUM;
        clr_we    = state == ST_CLEAR && !clear_done;
        ram_we    = enable && (acc_we || clr_we);
        ram_waddr = clr_we ? ptr : p1_addr;
        ram_wdata = clr_we ? '0 : sat;
        rd_addr   = (state == ST_ACCUM) ? syn_addr : ptr;
        idle      = state == ST_ACCUM && !p1_vld && !step_pending && !accept
                    && !next_step && !clear_act;
    end

    always_ff @(posedge clk) begin
        if (enable) begin
            if (ram_we)
                mem[ram_waddr] <= ram_wdata;
            ram_q <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            run           <= 1'b0;
            step_pending  <= 1'b0;
            step_again    <= 1'b0;
            p1_vld        <= 1'b0;
            p1_fwd        <= 1'b0;
            p1_addr       <= '0;
            p1_weight     <= '0;
            wr_q          <= '0;
            ptr           <= '0;
            touched       <= '0;
            neuron_vld    <= 1'b0;
            neuron_addr   <= '0;
            neuron_charge <= '0;
            clear_done    <= 1'b0;
            step_done     <= 1'b0;
        end else begin
            run <= 1'b1;
            if (enable) begin
                step_done <= idle;
                p1_vld    <= accept;
                if (accept) begin
                    p1_addr   <= syn_addr;
                    p1_weight <= syn_weight;
                    p1_fwd    <= acc_we && syn_addr == p1_addr;
                end
                if (acc_we) begin
                    touched[p1_addr] <= 1'b1;
                    wr_q             <= sat;
                end
                // A pulse arriving mid-drain queues one further (empty) drain.
                if (next_step) begin
                    if (state == ST_SCAN || state == ST_LOAD || state == ST_SEND)
                        step_again <= 1'b1;
                    else
                        step_pending <= 1'b1;
                end
                case (state)
                    ST_SCAN: if (!touched[ptr]) begin
                        if (ptr_last) begin
                            ptr          <= '0;
                            step_pending <= step_again || next_step;
                            step_again   <= 1'b0;
                        end else begin
                            ptr <= ptr + ADDR_W'(1);
                        end
                    end
                    ST_LOAD: begin
                        neuron_addr   <= ptr;
                        neuron_charge <= ram_q;
                        neuron_vld    <= 1'b1;
                    end
                    ST_SEND: if (neuron_rdy) begin
                        neuron_vld   <= 1'b0;
                        touched[ptr] <= 1'b0;
                        if (ptr_last) begin
                            ptr          <= '0;
                            step_pending <= step_again || next_step;
                            step_again   <= 1'b0;
                        end else begin
                            ptr <= ptr + ADDR_W'(1);
                        end
                    end
                    ST_CLEAR: if (!clear_done) begin
                        touched[ptr] <= 1'b0;
                        if (ptr_last) clear_done <= 1'b1;
                        else          ptr <= ptr + ADDR_W'(1);
                    end else if (!clear_act) begin
                        clear_done   <= 1'b0;
                        step_pending <= 1'b0;
                        step_again   <= 1'b0;
                        ptr          <= '0;
                    end
                    default: ;
                endcase
                if (clear_act && state != ST_CLEAR) begin
                    neuron_vld <= 1'b0;
                    p1_vld     <= 1'b0;
                    ptr        <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_ucaspian_dendrite.sv
// Scoreboard bench for ucaspian_dendrite: stimulus pushes expected drain words,
// a monitor pops and compares on every neuron handshake.
module tb_ucaspian_dendrite;
    logic        clk = 1'b0;
    logic        reset_n, enable, clear_act, clear_done, next_step, step_done;
    logic [7:0]  syn_addr, neuron_addr;
    logic [7:0]  syn_weight;
    logic        syn_vld, syn_rdy, neuron_vld, neuron_rdy;
    logic [15:0] neuron_charge;

    typedef struct {
        logic [7:0]         a;
        logic signed [15:0] c;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    logic        prev_vld = 1'b0, prev_rdy = 1'b0;
    logic [7:0]  prev_addr;
    logic [15:0] prev_charge;

    always #5 clk = ~clk;

    ucaspian_dendrite dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .clear_act(clear_act), .clear_done(clear_done),
        .next_step(next_step), .step_done(step_done),
        .syn_addr(syn_addr), .syn_weight(syn_weight),
        .syn_vld(syn_vld), .syn_rdy(syn_rdy),
        .neuron_addr(neuron_addr), .neuron_charge(neuron_charge),
        .neuron_vld(neuron_vld), .neuron_rdy(neuron_rdy)
    );

    always @(negedge clk) begin
        if (reset_n && !clear_act && prev_vld && !prev_rdy) begin
            checks++;
            if (!neuron_vld || neuron_addr != prev_addr || neuron_charge != prev_charge) begin
                errors++;
                $display("FAIL hold_stable vld=%0b addr=%0d charge=%0d required vld=1 addr=%0d charge=%0d",
                         neuron_vld, neuron_addr, $signed(neuron_charge), prev_addr, $signed(prev_charge));
            end
        end
        if (neuron_vld && neuron_rdy) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out addr=%0d charge=%0d required none",
                         neuron_addr, $signed(neuron_charge));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (neuron_addr != e.a || $signed(neuron_charge) != e.c) begin
                    errors++;
                    $display("FAIL drain_word addr=%0d charge=%0d required addr=%0d charge=%0d",
                             neuron_addr, $signed(neuron_charge), e.a, e.c);
                end
            end
        end
        prev_vld    = neuron_vld;
        prev_rdy    = neuron_rdy;
        prev_addr   = neuron_addr;
        prev_charge = neuron_charge;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    task automatic push(input logic [7:0] a, input int c);
        exp_t e;
        e.a = a;
        e.c = 16'(c);
        exp_q.push_back(e);
    endtask

    task automatic send_w(input logic [7:0] a, input logic [7:0] w);
        int n = 0;
        syn_addr   = a;
        syn_weight = w;
        syn_vld    = 1'b1;
        while (!syn_rdy && n < 50) begin
            tick();
            n++;
        end
        if (!syn_rdy) check("syn_rdy_timeout", 0, 1);
        tick();
    endtask

    task automatic pulse_step();
        syn_vld   = 1'b0;
        next_step = 1'b1;
        tick();
        next_step = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!step_done && n < budget) begin
            tick();
            n++;
        end
        check({name, "_step_done"}, int'(step_done), 1);
        check({name, "_queue_left"}, exp_q.size(), 0);
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b1; clear_act = 1'b0; next_step = 1'b0;
        syn_addr = '0; syn_weight = '0; syn_vld = 1'b0; neuron_rdy = 1'b1;
        tick(); tick();
        check("rst_vld", int'(neuron_vld), 0);
        check("rst_addr", int'(neuron_addr), 0);
        check("rst_charge", int'(neuron_charge), 0);
        check("rst_clear_done", int'(clear_done), 0);
        check("rst_step_done", int'(step_done), 0);
        check("rst_syn_rdy", int'(syn_rdy), 0);
        reset_n = 1'b1;
        tick();
        check("syn_rdy_after_rst", int'(syn_rdy), 1);
        tick();

        // basic accumulate, including same-address back-to-back
        send_w(8'd5, 8'd10);
        send_w(8'd5, 8'hFD);
        send_w(8'd9, 8'd127);
        push(8'd5, 7);
        push(8'd9, 127);
        pulse_step();
        check("step_done_low", int'(step_done), 0);
        wait_done("basic", 1000);

        // forwarding chain
        for (int i = 0; i < 4; i++) send_w(8'd3, 8'd100);
        push(8'd3, 400);
        pulse_step();
        wait_done("fwd", 1000);

        // saturation both directions
        for (int i = 0; i < 300; i++) send_w(8'd0, 8'd127);
        for (int i = 0; i < 300; i++) send_w(8'd1, 8'h80);
        push(8'd0, 32767);
        push(8'd1, -32768);
        pulse_step();
        wait_done("sat", 1000);

        // backpressure
        send_w(8'd2, 8'd5);
        send_w(8'd200, 8'hF9);
        push(8'd2, 5);
        push(8'd200, -7);
        neuron_rdy = 1'b0;
        pulse_step();
        begin
            int n = 0;
            while (!neuron_vld && n < 300) begin
                tick();
                n++;
            end
        end
        check("bp_vld_seen", int'(neuron_vld), 1);
        for (int i = 0; i < 20; i++) tick();
        check("bp_vld_held", int'(neuron_vld), 1);
        check("bp_addr_held", int'(neuron_addr), 2);
        check("bp_charge_held", int'(neuron_charge), 5);
        neuron_rdy = 1'b1;
        wait_done("bp", 1000);
        send_w(8'd2, 8'd1);
        push(8'd2, 1);
        pulse_step();
        wait_done("bp_next", 1000);

        // empty step: 256 scan cycles, no output, syn_rdy low throughout
        pulse_step();
        begin
            int bad_rdy = 0, bad_vld = 0;
            if (syn_rdy) bad_rdy++;
            for (int i = 0; i < 256; i++) begin
                tick();
                if (syn_rdy) bad_rdy++;
                if (neuron_vld) bad_vld++;
            end
            check("empty_syn_rdy_low_cycles", bad_rdy, 0);
            check("empty_vld_cycles", bad_vld, 0);
        end
        tick();
        check("empty_syn_rdy_back", int'(syn_rdy), 1);

        // clear mid-drain after 2 of 4 outputs
        send_w(8'd10, 8'd1);
        send_w(8'd20, 8'd2);
        send_w(8'd30, 8'd3);
        send_w(8'd40, 8'd4);
        push(8'd10, 1);
        push(8'd20, 2);
        pulse_step();
        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 300) begin
                tick();
                n++;
            end
        end
        check("clr_two_outputs", exp_q.size(), 0);
        clear_act = 1'b1;
        tick();
        check("clr_vld_drop", int'(neuron_vld), 0);
        check("clr_done_early", int'(clear_done), 0);
        for (int i = 0; i < 255; i++) tick();
        check("clr_done_255", int'(clear_done), 0);
        tick();
        check("clr_done_256", int'(clear_done), 1);
        tick();
        check("clr_done_held", int'(clear_done), 1);
        clear_act = 1'b0;
        tick();
        check("clr_done_fall", int'(clear_done), 0);
        pulse_step();
        wait_done("clr_after", 1000);

        // reset mid-accumulate
        syn_addr = 8'd7; syn_weight = 8'd5; syn_vld = 1'b1;
        tick(); tick();
        reset_n = 1'b0;
        tick();
        check("mid_rst_syn_rdy", int'(syn_rdy), 0);
        check("mid_rst_step_done", int'(step_done), 0);
        check("mid_rst_vld", int'(neuron_vld), 0);
        check("mid_rst_addr", int'(neuron_addr), 0);
        check("mid_rst_charge", int'(neuron_charge), 0);
        syn_vld = 1'b0;
        reset_n = 1'b1;
        tick();
        pulse_step();
        wait_done("post_rst", 1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
